// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory fetch slice.
// The boot image is only mapped when IMEM_BOOTROM_EN is defined.
package imem_pkg;

   localparam int ILEN       = 32;
   localparam int BOOT_WORDS = 16;

   localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } fetch_state_t;

   typedef struct packed {
      logic [ILEN-1:0] data;
      logic            err;
   } fetch_rsp_t;

   // Minimal boot stub: set mstatus.MIE, then spin.
   localparam logic [ILEN-1:0] BOOT_IMAGE [0:BOOT_WORDS-1] = '{
      32'h0000_0297,
      32'h0000_0013,
      32'h3004_6073,
      32'h0000_0013,
      32'h0000_0013,
      32'h0000_0013,
      32'h0000_0013,
      32'h0000_0013,
      32'h0000_0013,
      32'h0000_0013,
      32'h0000_0013,
      32'h0000_0013,
      32'h0000_0013,
      32'h0000_0013,
      32'h0000_0013,
      32'h0000_006f
   };

endpackage

// File: rtl/imem_array.sv
// Word storage: one registered read port, one write port, read-before-write.
// With IMEM_BOOTROM_EN the low words are a read-only boot image.
module imem_array
   import imem_pkg::*;
#(
   parameter  int XLEN  = 32,
   parameter  int DEPTH = 64,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [XLEN-1:0]  rd_data,
   input  logic             we,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [XLEN-1:0]  wr_data
);

   logic [XLEN-1:0] mem [DEPTH] = '{default: '0};
   logic            wr_ok;
   logic [XLEN-1:0] rd_word;

`ifdef IMEM_BOOTROM_EN
   assign wr_ok = we && (32'(wr_idx) >= 32'(BOOT_WORDS));

   always_comb begin
      rd_word = mem[rd_idx];
      if (32'(rd_idx) < 32'(BOOT_WORDS))
         rd_word = XLEN'(BOOT_IMAGE[rd_idx[3:0]]);
   end
`else
   assign wr_ok   = we;
   assign rd_word = mem[rd_idx];
`endif

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= rd_word;
   end

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch port: valid/ready request, 1+WAIT_STATES read latency,
// flush and program port. Optional boot ROM via IMEM_BOOTROM_EN.
module imem_fetch
   import imem_pkg::*;
#(
   parameter  int XLEN        = 32,
   parameter  int DEPTH       = 64,
   parameter  int AW          = 32,
   parameter  int WAIT_STATES = 0,
   localparam int IDX_W       = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [AW-1:0]    req_addr,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [XLEN-1:0]  rsp_data,
   output logic             rsp_err,
   input  logic             flush,
   input  logic             prog_we,
   input  logic [IDX_W-1:0] prog_addr,
   input  logic [XLEN-1:0]  prog_data
);

   localparam int         HI  = IDX_W + 2;
   localparam logic [3:0] WS4 = 4'(WAIT_STATES);

   fetch_state_t     state;
   logic [3:0]       cnt;
   logic [IDX_W-1:0] idx;
   logic             mis;
   logic             oor;
   logic             bad;
   logic             accept;
   logic [XLEN-1:0]  rd_data;

   assign idx = req_addr[HI-1:2];
   assign mis = |req_addr[1:0];

   if (AW > HI) begin : g_hi
      assign oor = |req_addr[AW-1:HI];
   end else begin : g_nohi
      assign oor = 1'b0;
   end

   assign bad = mis | oor;

   assign req_ready = !flush &&
                      (state == IDLE ||
                       (state == RESP && rsp_ready));

   assign accept = req_valid & req_ready;

   // Faulting fetches never read the array; the data lane is zeroed here.
   assign rsp_data = rsp_err ? '0 : rd_data;

   imem_array #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_en   (accept & ~bad),
      .rd_idx  (idx),
      .rd_data (rd_data),
      .we      (prog_we),
      .wr_idx  (prog_addr),
      .wr_data (prog_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         cnt       <= '0;
      end else if (flush) begin
         state     <= IDLE;
         rsp_valid <= 1'b0;
         cnt       <= '0;
      end else if (accept) begin
         rsp_err <= bad;
         if (WAIT_STATES > 0) begin
            state     <= WAIT;
            cnt       <= WS4;
            rsp_valid <= 1'b0;
         end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
         end
      end else if (state == WAIT) begin
         cnt <= cnt - 4'd1;
         if (cnt == 4'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
         end
      end else if (state == RESP && rsp_ready) begin
         state     <= IDLE;
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: one instance with zero and one with two wait states.
// Build with IMEM_BOOTROM_EN to exercise the boot ROM paths.
module tb_imem_fetch;
   import imem_pkg::*;

   typedef struct {
      int         d;
      fetch_rsp_t r;
      longint     cyc;
   } exp_t;

   logic        clk = 0;
   logic        rst_n = 0;
   logic        req_valid [2];
   logic        req_ready [2];
   logic [31:0] req_addr  [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_data  [2];
   logic        rsp_err   [2];
   logic        flush     [2];
   logic        prog_we   [2];
   logic [5:0]  prog_addr [2];
   logic [31:0] prog_data [2];

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   exp_t   sbq [$];

`ifdef IMEM_BOOTROM_EN
   localparam logic [31:0] W0 = 32'h0000_0297;
   localparam logic [31:0] W1 = 32'h0000_0013;
   localparam logic [31:0] W2 = 32'h3004_6073;
`else
   localparam logic [31:0] W0 = 32'h0000_0093;
   localparam logic [31:0] W1 = 32'h0010_0113;
   localparam logic [31:0] W2 = 32'h0020_0193;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   imem_fetch #(.WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_addr(req_addr[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
      .flush(flush[0]), .prog_we(prog_we[0]),
      .prog_addr(prog_addr[0]), .prog_data(prog_data[0])
   );

   imem_fetch #(.WAIT_STATES(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_addr(req_addr[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
      .flush(flush[1]), .prog_we(prog_we[1]),
      .prog_addr(prog_addr[1]), .prog_data(prog_data[1])
   );

   function automatic longint ws(int d);
      return (d == 1) ? 2 : 0;
   endfunction

   task automatic chk(string name, logic [31:0] act,
                      logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: pops one entry per completed handshake.
   always @(negedge clk) begin : mon
      bit     prev_v  [2];
      bit     prev_hs [2];
      longint start   [2];
      bit     hs;
      exp_t   e;
      for (int d = 0; d < 2; d++) begin
         if (rsp_valid[d] && (!prev_v[d] || prev_hs[d]))
            start[d] = cyc;
         hs = rsp_valid[d] && rsp_ready[d] && !flush[d] && rst_n;
         if (hs) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp dut%0d: got %h none expected",
                        d, rsp_data[d]);
            end else begin
               e = sbq.pop_front();
               chk($sformatf("rsp_dut dut%0d", d), d, e.d);
               chk($sformatf("rsp_data dut%0d", d), rsp_data[d], e.r.data);
               chk($sformatf("rsp_err dut%0d", d), 32'(rsp_err[d]),
                   32'(e.r.err));
               chk($sformatf("rsp_cycle dut%0d", d), 32'(start[d]),
                   32'(e.cyc));
            end
         end
         prev_v[d]  = rsp_valid[d];
         prev_hs[d] = hs;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic prog(int d, logic [5:0] a, logic [31:0] v);
      prog_we[d]   = 1;
      prog_addr[d] = a;
      prog_data[d] = v;
      step();
      prog_we[d] = 0;
   endtask

   task automatic fetch(int d, logic [31:0] a, logic [31:0] v,
                        logic err, bit push);
      bit   ok;
      exp_t e;
      ok = 0;
      req_valid[d] = 1;
      req_addr[d]  = a;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (req_ready[d]) begin
            ok = 1;
            if (push) begin
               e.d      = d;
               e.r.data = v;
               e.r.err  = err;
               e.cyc    = cyc + 1 + ws(d);
               sbq.push_back(e);
            end
         end
         step();
      end
      req_valid[d] = 0;
      chk("accept_in_budget", 32'(ok), 32'd1);
   endtask

   task automatic wait_valid(int d);
      bit ok;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = rsp_valid[d];
      end
      chk("valid_in_budget", 32'(ok), 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 8; i++) step();
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 0;
         req_addr[d]  = 0;
         rsp_ready[d] = 1;
         flush[d]     = 0;
         prog_we[d]   = 0;
         prog_addr[d] = 0;
         prog_data[d] = 0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("reset_valid", 32'(rsp_valid[d]), 32'd0);
         chk("reset_data", rsp_data[d], 32'd0);
         chk("reset_err", 32'(rsp_err[d]), 32'd0);
      end
      step();
      rst_n = 1;
      step();
      chk("idle_ready0", 32'(req_ready[0]), 32'd1);
      chk("idle_ready1", 32'(req_ready[1]), 32'd1);

      // Basic fetch, zero wait states
      prog(0, 6'd5, 32'h0010_0513);
      fetch(0, 32'h14, 32'h0010_0513, 0, 1);
      drain();

      // Two wait states with a stalled consumer
      prog(1, 6'd5, 32'h0010_0513);
      rsp_ready[1] = 0;
      fetch(1, 32'h14, 32'h0010_0513, 0, 1);
      wait_valid(1);
      for (int i = 0; i < 4; i++) begin
         chk("stall_data", rsp_data[1], 32'h0010_0513);
         chk("stall_valid", 32'(rsp_valid[1]), 32'd1);
         chk("stall_req_ready", 32'(req_ready[1]), 32'd0);
         step();
         @(negedge clk);
      end
      step();
      rsp_ready[1] = 1;
      drain();

      // Write during WAIT keeps the captured word
      prog(1, 6'd7, 32'h1111_1111);
      fetch(1, 32'h1C, 32'h1111_1111, 0, 1);
      prog(1, 6'd7, 32'h2222_2222);
      fetch(1, 32'h1C, 32'h2222_2222, 0, 1);
      drain();

      // Back-to-back, one word per cycle
`ifndef IMEM_BOOTROM_EN
      prog(0, 6'd0, W0);
      prog(0, 6'd1, W1);
      prog(0, 6'd2, W2);
`endif
      fetch(0, 32'h00, W0, 0, 1);
      fetch(0, 32'h04, W1, 0, 1);
      fetch(0, 32'h08, W2, 0, 1);
      drain();

      // Address faults and the top in-range word
      prog(0, 6'd63, 32'hCAFE_F00D);
      fetch(0, 32'h06, 32'h0, 1, 1);
      fetch(0, 32'h100, 32'h0, 1, 1);
      fetch(0, 32'hFC, 32'hCAFE_F00D, 0, 1);
      fetch(0, 32'hFFFF_FFFC, 32'h0, 1, 1);
      drain();

      // Flush during WAIT drops the fetch
      fetch(1, 32'h14, 32'h0, 0, 0);
      flush[1] = 1;
      @(negedge clk);
      chk("flush_req_ready", 32'(req_ready[1]), 32'd0);
      step();
      flush[1] = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("flushed_no_valid", 32'(rsp_valid[1]), 32'd0);
      end
      step();
      fetch(1, 32'h14, 32'h0010_0513, 0, 1);
      drain();

      // Flush in RESP beats rsp_ready
      rsp_ready[0] = 0;
      fetch(0, 32'h14, 32'h0, 0, 0);
      flush[0]     = 1;
      rsp_ready[0] = 1;
      @(negedge clk);
      chk("flush_resp_req_ready", 32'(req_ready[0]), 32'd0);
      chk("flush_resp_valid", 32'(rsp_valid[0]), 32'd1);
      step();
      flush[0] = 0;
      @(negedge clk);
      chk("flush_resp_idle", 32'(rsp_valid[0]), 32'd0);
      chk("flush_resp_ready", 32'(req_ready[0]), 32'd1);
      drain();

      // Async reset during WAIT and during RESP
      fetch(1, 32'h14, 32'h0, 0, 0);
      #1 rst_n = 0;
      #1 chk("rst_wait_valid", 32'(rsp_valid[1]), 32'd0);
      step();
      rst_n = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_rst_valid", 32'(rsp_valid[1]), 32'd0);
         chk("post_rst_ready", 32'(req_ready[1]), 32'd1);
      end
      step();
      rsp_ready[0] = 0;
      fetch(0, 32'h14, 32'h0, 0, 0);
      chk("pre_rst_valid", 32'(rsp_valid[0]), 32'd1);
      #1 rst_n = 0;
      #1 chk("rst_resp_valid", 32'(rsp_valid[0]), 32'd0);
      step();
      rst_n = 1;
      rsp_ready[0] = 1;
      drain();

      // Word 2: boot ROM is read-only, otherwise writable
      prog(0, 6'd2, 32'hDEAD_BEEF);
`ifdef IMEM_BOOTROM_EN
      fetch(0, 32'h08, 32'h3004_6073, 0, 1);
`else
      fetch(0, 32'h08, 32'hDEAD_BEEF, 0, 1);
`endif

      // Same-cycle write and accept returns the old word
      prog(0, 6'd20, 32'h0010_0073);
      fetch(0, 32'h50, 32'h0010_0073, 0, 1);
      prog_we[0]   = 1;
      prog_addr[0] = 6'd20;
      prog_data[0] = 32'h5555_AAAA;
      fetch(0, 32'h50, 32'h0010_0073, 0, 1);
      prog_we[0] = 0;
      fetch(0, 32'h50, 32'h5555_AAAA, 0, 1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
